vector_memory: RTL and testbench
================================

// Module: vector_memory
// PURPOSE
//  Main-memory responder on the processing_block load/write interface.
//  Serves 512-bit (32 x 16-bit lane) lines: loads return data one cycle after the request, writes commit at the clock edge.
//  Side host port preloads and inspects contents for bring-up and tests.
//  Zero-scrubs storage after reset; signals mem_ready when done.
// PARAMETERS
//  LINE_W  512  line width in bits (32 lanes x 16 b)
//  ADDR_W  16   address port width
//  DEPTH   256  implemented lines; addresses >= DEPTH are out of range
// PORTS
//  clock       in   1       rising-edge clock
//  reset_n     in   1       asynchronous, active-low reset
//  load_ctrl   in   1       load request, sampled each edge
//  load_addr   in   ADDR_W  load line address
//  load_data   out  LINE_W  registered read data
//  write_ctrl  in   1       write request, sampled each edge
//  write_addr  in   ADDR_W  write line address
//  write_data  in   LINE_W  write line data
//  host_we     in   1       host write strobe
//  host_re     in   1       host read strobe
//  host_addr   in   ADDR_W  host line address
//  host_wdata  in   LINE_W  host write data
//  host_rdata  out  LINE_W  registered host read data, 1-cycle latency
//  host_drop   out  1       1-cycle pulse: host write lost to a PB write at the same address
//  mem_ready   out  1       scrub done, requests honoured
//  addr_err    out  1       sticky: out-of-range access seen
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - load_data=0, host_rdata=0, host_drop=0, mem_ready=0, addr_err=0.
//   - Scrub counter=0; FSM enters SCRUB.
//  FSM SCRUB:
//   - Writes 0 to line[cnt] each cycle, cnt++.
//   - At cnt==DEPTH-1: write it, set mem_ready=1, go to SERVE (DEPTH cycles total).
//   - All load/write/host requests are ignored; load_data and host_rdata hold 0.
//  FSM SERVE (stays until reset):
//   - Load: load_ctrl=1 at edge N -> load_data = line[load_addr] after edge N.
//     load_data holds its value while load_ctrl=0.
//   - Write: write_ctrl=1 commits write_data to line[write_addr] at the edge.
//   - Same-edge load and write to one address: load_data returns the new write_data (write-first forwarding).
//   - Host read: same 1-cycle timing and write-first forwarding as loads.
//     Forwarding source is the PB write if present, otherwise the host write.
//   - Host write, different address from any PB write: both commit.
//   - Host write, same address as a PB write: PB write wins, host write dropped, host_drop=1 for one cycle.
//   - Out-of-range address (>= DEPTH):
//     - Load or host read returns 0.
//     - Write is dropped.
//     - addr_err set; cleared only by reset.
//  Reset mid-operation: in-flight load is lost and outputs go to reset values.
//   Contents are re-scrubbed to zero.
//  Lane order: lane i = bits [16i+15:16i]. Data is stored verbatim; no arithmetic.
// STRUCTURE
//  Shared pkg pb_pkg:
//   - LINE_W, LANES=32, LANE_W=16, ADDR_W.
//   - typedef line_t = logic[LINE_W-1:0].
//   - typedef enum {SCRUB, SERVE} mem_state_t.
//  Sub-module vector_mem_array: DEPTH x LINE_W storage with two write ports (PB priority) and two registered read ports.
//  Top owns the FSM, scrub counter, range checks, forwarding muxes and error flags.
// TESTING
//  1 Release reset; mem_ready stays 0 for exactly DEPTH cycles, then 1.
//    Load addr 7 -> load_data == 0.
//  2 Host-write addr0 = {32{16'h3e4d}}, addr1 = {32{16'h4000}}.
//    Load 0 then 1 on consecutive cycles -> data appears one cycle after each request.
//  3 PB write addr3 = {32{16'h3f1a}}, then load 3 -> 3f1a x32.
//    Host read 3 gives the same.
//  4 Same edge: write addr5 = {32{16'h1234}} and load 5 -> load_data == 1234 x32 next cycle.
//  5 Same edge: PB write and host write to addr 9 -> PB data stored, host_drop pulses once.
//  6 Load 300 -> load_data 0, addr_err=1.
//    Assert reset_n=0 mid-load -> all outputs 0 immediately; rescrub; addr 0 reads 0.

Source files
------------

// File: rtl/pb_pkg.sv
// ----------------------------------------------------------------------------
// pb_pkg
//   Shared definitions for the processing_block memory interface: line and
//   lane geometry, address width, default memory depth, the line/address
//   types and the responder FSM state encoding.
// ----------------------------------------------------------------------------
package pb_pkg;

    localparam int LANES     = 32;
    localparam int LANE_W    = 16;
    localparam int LINE_W    = LANES * LANE_W;   // 512
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 256;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        SCRUB = 1'b0,
        SERVE = 1'b1
    } mem_state_t;

    // Broadcast one lane value to every lane of a line (lane i = bits
    // [16i+15:16i]).
    function automatic line_t fill_lanes(input lane_t value);
        return {LANES{value}};
    endfunction

endpackage

// File: rtl/vector_mem_array.sv
// ----------------------------------------------------------------------------
// vector_mem_array
//   DEPTH x LINE_W line storage with two write ports and two registered read
//   ports.
//   Write ports:
//     wa_*  primary port (scrub / PB write); wins over wb_* on the same index
//     wb_*  secondary port (host write)
//   Read ports (a = PB load, b = host read), each:
//     r*_en_i        capture a new value into the output register
//     r*_idx_i       line index to read
//     r*_zero_i      return zero instead of stored data (out-of-range access)
//     r*_fwd_i       return r*_fwd_data_i instead of stored data (same-edge
//                    write forwarding, selected by the caller)
//     r*_data_o      registered read data, held while r*_en_i is low
// ----------------------------------------------------------------------------
module vector_mem_array
    import pb_pkg::*;
#(
    parameter  int DEPTH = MEM_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    // write port A (priority)
    input  logic              wa_en_i,
    input  logic [IDX_W-1:0]  wa_idx_i,
    input  logic [LINE_W-1:0] wa_data_i,
    // write port B
    input  logic              wb_en_i,
    input  logic [IDX_W-1:0]  wb_idx_i,
    input  logic [LINE_W-1:0] wb_data_i,
    // read port A
    input  logic              ra_en_i,
    input  logic [IDX_W-1:0]  ra_idx_i,
    input  logic              ra_zero_i,
    input  logic              ra_fwd_i,
    input  logic [LINE_W-1:0] ra_fwd_data_i,
    output logic [LINE_W-1:0] ra_data_o,
    // read port B
    input  logic              rb_en_i,
    input  logic [IDX_W-1:0]  rb_idx_i,
    input  logic              rb_zero_i,
    input  logic              rb_fwd_i,
    input  logic [LINE_W-1:0] rb_fwd_data_i,
    output logic [LINE_W-1:0] rb_data_o
);

    line_t mem_q [DEPTH];
    line_t ra_q;
    line_t rb_q;

    // NOTE: the storage array has no reset branch; a reset would turn it into
    // DEPTH*LINE_W flops instead of RAM. Zero contents after reset come from
    // the scrub pass driven by the top level.
    always_ff @(posedge clk) begin
        if (wb_en_i) begin
            mem_q[wb_idx_i] <= wb_data_i;
        end
        // Issued last so port A wins when both ports hit one index.
        if (wa_en_i) begin
            mem_q[wa_idx_i] <= wa_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q <= '0;
        end else if (ra_en_i) begin
            if (ra_zero_i) begin
                ra_q <= '0;
            end else if (ra_fwd_i) begin
                ra_q <= ra_fwd_data_i;
            end else begin
                ra_q <= mem_q[ra_idx_i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q <= '0;
        end else if (rb_en_i) begin
            if (rb_zero_i) begin
                rb_q <= '0;
            end else if (rb_fwd_i) begin
                rb_q <= rb_fwd_data_i;
            end else begin
                rb_q <= mem_q[rb_idx_i];
            end
        end
    end

    assign ra_data_o = ra_q;
    assign rb_data_o = rb_q;

endmodule

// File: rtl/vector_memory.sv
// ----------------------------------------------------------------------------
// vector_memory
//   Main-memory responder on the processing_block load/write interface.
//   Serves 512-bit lines (32 x 16-bit lanes). Loads and host reads return
//   data one cycle after the request; writes commit at the clock edge. After
//   reset every line is scrubbed to zero before requests are honoured.
//
//   Ports:
//     clock, reset_n            rising-edge clock, async active-low reset
//     load_ctrl/load_addr       PB load request
//     load_data                 registered load data (held between loads)
//     write_ctrl/write_addr/
//     write_data                PB write request
//     host_we/host_re/host_addr/
//     host_wdata                host side port (preload / inspect)
//     host_rdata                registered host read data
//     host_drop                 1-cycle pulse: host write lost to PB write
//     mem_ready                 scrub finished, requests are honoured
//     addr_err                  sticky out-of-range access flag
// ----------------------------------------------------------------------------
module vector_memory
    import pb_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_ctrl,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [LINE_W-1:0] load_data,
    input  logic              write_ctrl,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [LINE_W-1:0] write_data,
    input  logic              host_we,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LINE_W-1:0] host_wdata,
    output logic [LINE_W-1:0] host_rdata,
    output logic              host_drop,
    output logic              mem_ready,
    output logic              addr_err
);

    localparam int                 IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0]    LIMIT    = (ADDR_W + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < LIMIT;
    endfunction

    mem_state_t       state_q;
    logic [IDX_W-1:0] scrub_cnt_q;
    logic             mem_ready_q;
    logic             addr_err_q, addr_err_d;
    logic             host_drop_q, host_drop_d;

    logic             serve;
    logic             load_ok, write_ok, host_ok;
    logic             pb_wr, host_wr_req, host_wr, collide;

    logic             wa_en;
    logic [IDX_W-1:0] wa_idx;
    line_t            wa_data;

    logic             ld_fwd_pb, ld_fwd_host;
    logic             hr_fwd_pb, hr_fwd_host;
    line_t            ld_fwd_data, hr_fwd_data;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign serve    = (state_q == SERVE);
    assign load_ok  = in_range(load_addr);
    assign write_ok = in_range(write_addr);
    assign host_ok  = in_range(host_addr);

    assign pb_wr       = serve & write_ctrl & write_ok;
    assign host_wr_req = serve & host_we & host_ok;
    // A PB write to the same line takes the slot; the host write is lost.
    assign collide     = pb_wr & host_wr_req & (write_addr == host_addr);
    assign host_wr     = host_wr_req & ~collide;

    // Write port A carries the scrub stream until SERVE, then PB writes.
    assign wa_en   = ~serve | pb_wr;
    assign wa_idx  = serve ? write_addr[IDX_W-1:0] : scrub_cnt_q;
    assign wa_data = serve ? write_data : '0;

    // ------------------------------------------------------------------
    // Write-first forwarding: a read on the same edge as a committing
    // write returns the new data. The PB write is the preferred source.
    // ------------------------------------------------------------------
    assign ld_fwd_pb   = pb_wr   & (write_addr == load_addr);
    assign ld_fwd_host = host_wr & (host_addr  == load_addr);
    assign ld_fwd_data = ld_fwd_pb ? write_data : host_wdata;

    assign hr_fwd_pb   = pb_wr   & (write_addr == host_addr);
    assign hr_fwd_host = host_wr;   // host write and host read share host_addr
    assign hr_fwd_data = hr_fwd_pb ? write_data : host_wdata;

    // ------------------------------------------------------------------
    // Flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        addr_err_d  = addr_err_q;
        host_drop_d = collide;
        if (serve && ((load_ctrl  && !load_ok)  ||
                      (write_ctrl && !write_ok) ||
                      ((host_we || host_re) && !host_ok))) begin
            addr_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scrub / serve FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
            host_drop_q <= 1'b0;
        end else begin
            addr_err_q  <= addr_err_d;
            host_drop_q <= host_drop_d;
            case (state_q)
                SCRUB: begin
                    if (scrub_cnt_q == LAST_IDX) begin
                        mem_ready_q <= 1'b1;
                        state_q     <= SERVE;
                    end else begin
                        scrub_cnt_q <= scrub_cnt_q + IDX_W'(1);
                    end
                end
                SERVE: begin
                    // Stays here until reset.
                end
                default: begin
                    state_q <= SCRUB;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    vector_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk           (clock),
        .rst_n         (reset_n),
        .wa_en_i       (wa_en),
        .wa_idx_i      (wa_idx),
        .wa_data_i     (wa_data),
        .wb_en_i       (host_wr),
        .wb_idx_i      (host_addr[IDX_W-1:0]),
        .wb_data_i     (host_wdata),
        .ra_en_i       (serve & load_ctrl),
        .ra_idx_i      (load_addr[IDX_W-1:0]),
        .ra_zero_i     (~load_ok),
        .ra_fwd_i      (ld_fwd_pb | ld_fwd_host),
        .ra_fwd_data_i (ld_fwd_data),
        .ra_data_o     (load_data),
        .rb_en_i       (serve & host_re),
        .rb_idx_i      (host_addr[IDX_W-1:0]),
        .rb_zero_i     (~host_ok),
        .rb_fwd_i      (hr_fwd_pb | hr_fwd_host),
        .rb_fwd_data_i (hr_fwd_data),
        .rb_data_o     (host_rdata)
    );

    assign mem_ready = mem_ready_q;
    assign addr_err  = addr_err_q;
    assign host_drop = host_drop_q;

endmodule

// File: tb/tb_vector_memory.sv
// ----------------------------------------------------------------------------
// tb_vector_memory
//   Self-checking bench for vector_memory: a table of single-cycle request
//   vectors with expected results (queued on drive, popped one edge later),
//   plus hand-written sequences for scrub timing, lane order and reset
//   during a load.
// ----------------------------------------------------------------------------
module tb_vector_memory;
    import pb_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              load_ctrl;
    logic [ADDR_W-1:0] load_addr;
    logic [LINE_W-1:0] load_data;
    logic              write_ctrl;
    logic [ADDR_W-1:0] write_addr;
    logic [LINE_W-1:0] write_data;
    logic              host_we;
    logic              host_re;
    logic [ADDR_W-1:0] host_addr;
    logic [LINE_W-1:0] host_wdata;
    logic [LINE_W-1:0] host_rdata;
    logic              host_drop;
    logic              mem_ready;
    logic              addr_err;

    always #5 clock = ~clock;

    vector_memory dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_ctrl  (load_ctrl),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .write_ctrl (write_ctrl),
        .write_addr (write_addr),
        .write_data (write_data),
        .host_we    (host_we),
        .host_re    (host_re),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_drop  (host_drop),
        .mem_ready  (mem_ready),
        .addr_err   (addr_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ld;   logic [15:0] ld_a;
        logic        wr;   logic [15:0] wr_a;  logic [15:0] wr_v;
        logic        hwe;  logic        hre;   logic [15:0] h_a;  logic [15:0] h_v;
        logic        chk_ld; logic [15:0] exp_ld;
        logic        chk_hr; logic [15:0] exp_hr;
        logic        exp_drop;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int    idx;
        logic  chk_ld; line_t ld;
        logic  chk_hr; line_t hr;
        logic  drop;
        logic  err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check_line(input string name, input line_t act, input line_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ld,  input logic [15:0] ld_a,
        input logic wr,  input logic [15:0] wr_a, input logic [15:0] wr_v,
        input logic hwe, input logic hre, input logic [15:0] h_a, input logic [15:0] h_v,
        input logic chk_ld, input logic [15:0] exp_ld,
        input logic chk_hr, input logic [15:0] exp_hr,
        input logic drop, input logic err);
        vec_t v;
        v.ld = ld;   v.ld_a = ld_a;
        v.wr = wr;   v.wr_a = wr_a; v.wr_v = wr_v;
        v.hwe = hwe; v.hre = hre; v.h_a = h_a; v.h_v = h_v;
        v.chk_ld = chk_ld; v.exp_ld = exp_ld;
        v.chk_hr = chk_hr; v.exp_hr = exp_hr;
        v.exp_drop = drop; v.exp_err = err;
        return v;
    endfunction

    task automatic idle();
        load_ctrl  = 1'b0; load_addr  = '0;
        write_ctrl = 1'b0; write_addr = '0; write_data = '0;
        host_we    = 1'b0; host_re    = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic drive(input vec_t v);
        load_ctrl  = v.ld;  load_addr  = v.ld_a;
        write_ctrl = v.wr;  write_addr = v.wr_a; write_data = fill_lanes(v.wr_v);
        host_we    = v.hwe; host_re    = v.hre;
        host_addr  = v.h_a; host_wdata = fill_lanes(v.h_v);
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int cycles = 0;
        while (mem_ready !== 1'b1 && cycles < 2 * MEM_DEPTH) begin
            tick();
            cycles++;
        end
        check_val({name, " scrub cycles"}, cycles, MEM_DEPTH);
        check_val({name, " mem_ready"}, int'(mem_ready), 1);
    endtask

    task automatic single_load(input string name, input logic [15:0] addr, input line_t exp);
        idle();
        load_ctrl = 1'b1;
        load_addr = addr;
        tick();
        check_line(name, load_data, exp);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t  e;
        line_t pat;

        // ld  ld_a   wr  wr_a  wr_v     hwe hre h_a   h_v      cL  expL     cH  expH     drop err
        tbl.push_back(mk(1, 16'd7,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h0000, 0, 16'h0,    0, 0)); //  0
        tbl.push_back(mk(0, 16'd0,   0, 16'd0,   16'h0,    1, 0, 16'd0,   16'h3e4d, 0, 16'h0,    0, 16'h0,    0, 0)); //  1
        tbl.push_back(mk(0, 16'd0,   0, 16'd0,   16'h0,    1, 0, 16'd1,   16'h4000, 0, 16'h0,    0, 16'h0,    0, 0)); //  2
        tbl.push_back(mk(1, 16'd0,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h3e4d, 0, 16'h0,    0, 0)); //  3
        tbl.push_back(mk(1, 16'd1,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h4000, 0, 16'h0,    0, 0)); //  4
        tbl.push_back(mk(0, 16'd0,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h4000, 0, 16'h0,    0, 0)); //  5 hold
        tbl.push_back(mk(0, 16'd0,   1, 16'd3,   16'h3f1a, 0, 0, 16'd0,   16'h0,    0, 16'h0,    0, 16'h0,    0, 0)); //  6
        tbl.push_back(mk(1, 16'd3,   0, 16'd0,   16'h0,    0, 1, 16'd3,   16'h0,    1, 16'h3f1a, 1, 16'h3f1a, 0, 0)); //  7
        tbl.push_back(mk(1, 16'd5,   1, 16'd5,   16'h1234, 0, 0, 16'd0,   16'h0,    1, 16'h1234, 0, 16'h0,    0, 0)); //  8
        tbl.push_back(mk(0, 16'd0,   1, 16'd9,   16'haaaa, 1, 0, 16'd9,   16'h5555, 0, 16'h0,    0, 16'h0,    1, 0)); //  9
        tbl.push_back(mk(1, 16'd9,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'haaaa, 1, 16'h3f1a, 0, 0)); // 10
        tbl.push_back(mk(0, 16'd0,   1, 16'd11,  16'hcafe, 1, 1, 16'd10,  16'hbeef, 0, 16'h0,    1, 16'hbeef, 0, 0)); // 11
        tbl.push_back(mk(1, 16'd10,  0, 16'd0,   16'h0,    0, 1, 16'd11,  16'h0,    1, 16'hbeef, 1, 16'hcafe, 0, 0)); // 12
        tbl.push_back(mk(0, 16'd0,   1, 16'd12,  16'h0f0f, 0, 1, 16'd12,  16'h0,    0, 16'h0,    1, 16'h0f0f, 0, 0)); // 13
        tbl.push_back(mk(0, 16'd0,   1, 16'd13,  16'h1111, 1, 1, 16'd13,  16'h2222, 0, 16'h0,    1, 16'h1111, 1, 0)); // 14
        tbl.push_back(mk(1, 16'd13,  0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h1111, 0, 16'h0,    0, 0)); // 15
        tbl.push_back(mk(1, 16'd300, 0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h0000, 0, 16'h0,    0, 1)); // 16
        tbl.push_back(mk(0, 16'd0,   1, 16'd300, 16'hdead, 0, 0, 16'd0,   16'h0,    0, 16'h0,    0, 16'h0,    0, 1)); // 17
        tbl.push_back(mk(1, 16'd44,  0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h0000, 0, 16'h0,    0, 1)); // 18
        tbl.push_back(mk(0, 16'd0,   0, 16'd0,   16'h0,    0, 1, 16'd999, 16'h0,    0, 16'h0,    1, 16'h0000, 0, 1)); // 19
        tbl.push_back(mk(1, 16'd3,   0, 16'd0,   16'h0,    0, 0, 16'd0,   16'h0,    1, 16'h3f1a, 0, 16'h0,    0, 1)); // 20

        // ---------------- reset and first scrub ----------------
        reset_n = 1'b0;
        idle();
        repeat (2) tick();
        check_line("reset load_data", load_data, '0);
        check_line("reset host_rdata", host_rdata, '0);
        check_val("reset host_drop", int'(host_drop), 0);
        check_val("reset mem_ready", int'(mem_ready), 0);
        check_val("reset addr_err", int'(addr_err), 0);
        reset_n = 1'b1;
        wait_ready("first");

        // ---------------- table-driven vectors ----------------
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e.idx    = i;
            e.chk_ld = tbl[i].chk_ld; e.ld = fill_lanes(tbl[i].exp_ld);
            e.chk_hr = tbl[i].chk_hr; e.hr = fill_lanes(tbl[i].exp_hr);
            e.drop   = tbl[i].exp_drop;
            e.err    = tbl[i].exp_err;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            if (e.chk_ld) check_line($sformatf("v%0d load_data", e.idx), load_data, e.ld);
            if (e.chk_hr) check_line($sformatf("v%0d host_rdata", e.idx), host_rdata, e.hr);
            check_val($sformatf("v%0d host_drop", e.idx), int'(host_drop), int'(e.drop));
            check_val($sformatf("v%0d addr_err", e.idx), int'(addr_err), int'(e.err));
        end
        idle();

        // ---------------- lane order: distinct lanes ----------------
        for (int i = 0; i < LANES; i++) begin
            pat[i*LANE_W +: LANE_W] = {8'(i), 8'ha5};
        end
        host_we = 1'b1; host_addr = 16'd20; host_wdata = pat;
        tick();
        idle();
        load_ctrl = 1'b1; load_addr = 16'd20;
        host_re   = 1'b1; host_addr = 16'd20;
        tick();
        check_line("lanes load_data", load_data, pat);
        check_line("lanes host_rdata", host_rdata, pat);
        check_val("lane0", int'(load_data[15:0]), 16'h00a5);
        check_val("lane31", int'(load_data[511:496]), 16'h1fa5);
        idle();

        // ---------------- reset during a load ----------------
        load_ctrl = 1'b1; load_addr = 16'd0;
        #2 reset_n = 1'b0;
        #1;
        check_line("midreset load_data", load_data, '0);
        check_line("midreset host_rdata", host_rdata, '0);
        check_val("midreset host_drop", int'(host_drop), 0);
        check_val("midreset mem_ready", int'(mem_ready), 0);
        check_val("midreset addr_err", int'(addr_err), 0);
        tick();
        // Requests held throughout the scrub must all be ignored.
        write_ctrl = 1'b1; write_addr = 16'd0;  write_data = fill_lanes(16'hffff);
        host_we    = 1'b1; host_addr  = 16'd1;  host_wdata = fill_lanes(16'h5a5a);
        load_ctrl  = 1'b1; load_addr  = 16'd20;
        reset_n    = 1'b1;
        wait_ready("rescrub");
        check_line("rescrub load_data held", load_data, '0);
        idle();
        single_load("rescrub addr0", 16'd0, '0);
        single_load("rescrub addr1", 16'd1, '0);
        single_load("rescrub addr20", 16'd20, '0);
        check_val("rescrub addr_err", int'(addr_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
